// File: rtl/runner_world.sv
// Endless-runner game core: a scrolling obstacle field, a jumping runner and collision detection.
// Define RUNNER_SCORE_EN to build the cleared-obstacle score counter; otherwise score is tied to zero.
module runner_world #(
  parameter int          COLS  = 80,
  parameter int          OBS_W = 2,
  parameter int          H_W   = 7,
  parameter int          RATE  = 750000,
  parameter int          HOLD  = 15,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    go,
  input  logic                    stop,
  input  logic                    jump,
  output logic [1:0]              state,
  output logic                    tick,
  output logic [COLS*OBS_W-1:0]   cols,
  output logic [H_W-1:0]          runner_h,
  output logic                    collide,
  output logic [15:0]             score
);

  localparam int DIV_W  = $clog2(RATE);
  localparam int RISE_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int CMP_W  = (OBS_W > H_W) ? OBS_W : H_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t                  state_q, state_nx;
  logic [DIV_W-1:0]        div_q;
  logic                    tick_q, collide_q;
  logic [COLS*OBS_W-1:0]   cols_q, cols_nx;
  logic [H_W-1:0]          h_q, h_nx;
  logic [RISE_W-1:0]       rise_q, rise_nx;
  logic                    jump_req_q;
  logic [15:0]             lfsr_q, lfsr_nx;
  logic [1:0]              gap_q, gap_nx;
  logic [OBS_W-1:0]        new_col;
  logic [CMP_W-1:0]        top_ext, h_ext;
  logic                    tick_now, hit, clr;

  assign tick_now = (state_q == S_RUN) && (div_q == '0);

  // Obstacle generation uses the LFSR value held before this tick's step.
  always_comb begin
    new_col = '0;
    gap_nx  = gap_q;
    if (gap_q != 2'd0) begin
      gap_nx = gap_q - 2'd1;
    end else if (lfsr_q[7:5] == 3'd0) begin
      new_col = lfsr_q[OBS_W-1:0];
      if (new_col != '0) gap_nx = 2'd2;
    end
    lfsr_nx = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cols_nx = {cols_q[(COLS-1)*OBS_W-1:0], new_col};
  end

  always_comb begin
    rise_nx = rise_q;
    h_nx    = h_q;
    if ((jump_req_q || jump) && (h_q == '0)) begin
      rise_nx = RISE_W'(HOLD);
      h_nx    = {{(H_W-1){1'b0}}, 1'b1};
    end else if (rise_q != '0) begin
      rise_nx = rise_q - 1'b1;
      h_nx    = (h_q == '1) ? h_q : h_q + 1'b1;
    end else if (h_q != '0) begin
      h_nx    = h_q - 1'b1;
    end
  end

  // Collision is judged on the post-shift, post-move picture.
  assign top_ext = CMP_W'(cols_nx[(COLS-1)*OBS_W +: OBS_W]);
  assign h_ext   = CMP_W'(h_nx);
  assign hit     = top_ext > h_ext;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: if (go) state_nx = S_RUN;
      S_RUN: begin
        if (stop)                 state_nx = S_IDLE;
        else if (tick_now && hit) state_nx = S_OVER;
      end
      S_OVER: if (go) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    state    = state_q;
    tick     = tick_q;
    collide  = collide_q;
    cols     = cols_q;
    runner_h = h_q;
  end

  // Any path into IDLE clears the world in the same edge.
  assign clr = (state_nx == S_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      div_q      <= DIV_W'(RATE - 1);
      tick_q     <= 1'b0;
      collide_q  <= 1'b0;
      cols_q     <= '0;
      h_q        <= '0;
      rise_q     <= '0;
      jump_req_q <= 1'b0;
      lfsr_q     <= SEED;
      gap_q      <= 2'd0;
    end else begin
      tick_q    <= tick_now;
      collide_q <= tick_now && hit && (state_q == S_RUN);
      if (state_q == S_RUN) begin
        div_q <= tick_now ? DIV_W'(RATE - 1) : div_q - 1'b1;
        if (jump) jump_req_q <= 1'b1;
        if (tick_now) begin
          jump_req_q <= 1'b0;
          lfsr_q     <= lfsr_nx;
          cols_q     <= cols_nx;
          gap_q      <= gap_nx;
          rise_q     <= rise_nx;
          h_q        <= h_nx;
        end
      end
    end
  end

`ifdef RUNNER_SCORE_EN
  logic [15:0] score_q;

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      score_q <= 16'h0000;
    end else if (tick_now && !hit && (top_ext != '0) && (score_q != 16'hFFFF)) begin
      score_q <= score_q + 16'h0001;
    end
  end

  assign score = score_q;
`else
  assign score = 16'h0000;
`endif

endmodule

// File: tb/tb_runner_world.sv
// Directed bench for runner_world on a small 8-column world with fast ticks.
// Seed 16'h0003 drops a height-3 obstacle on tick 1 and nothing else through tick 8.
module tb_runner_world;

  logic        clk;
  logic        resetn;
  logic        go, stop, jump;
  logic [1:0]  state;
  logic        tick;
  logic [15:0] cols;
  logic [6:0]  runner_h;
  logic        collide;
  logic [15:0] score;

  int total = 0;
  int bad   = 0;
  int exp_h [8] = '{1, 2, 3, 4, 3, 2, 1, 0};

  runner_world #(
    .COLS(8), .OBS_W(2), .H_W(7), .RATE(4), .HOLD(3), .SEED(16'h0003)
  ) dut (
    .clk(clk), .resetn(resetn), .go(go), .stop(stop), .jump(jump),
    .state(state), .tick(tick), .cols(cols), .runner_h(runner_h),
    .collide(collide), .score(score)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic enter_run();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    go = 1'b1; stop = 1'b0; jump = 1'b1;
    step();
    step();
    go = 1'b0; jump = 1'b0;
    total++;
    if (state !== 2'd0 || tick !== 1'b0 || collide !== 1'b0 || cols !== 16'h0 ||
        runner_h !== 7'd0 || score !== 16'h0) begin
      bad++;
      $display("FAIL reset: state=%0d tick=%b collide=%b cols=%h h=%0d score=%0d want all zero",
               state, tick, collide, cols, runner_h, score);
    end
    resetn = 1'b1;
  endtask

  task automatic test_divider();
    for (int i = 1; i <= 8; i++) begin
      step();
      total++;
      if (tick !== 1'b0 || state !== 2'd0) begin
        bad++;
        $display("FAIL idle_quiet: cycle %0d tick=%b state=%0d want 0 0", i, tick, state);
      end
    end
    go = 1'b1;
    step();
    go = 1'b0;
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL enter_run: state=%0d want 1", state);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      total++;
      if (tick !== ((i % 4) == 0)) begin
        bad++;
        $display("FAIL div_tick: cycle %0d tick=%b want %b", i, tick, (i % 4) == 0);
      end
    end
  endtask

  task automatic test_jump();
    enter_run();
    step();
    jump = 1'b1;
    step();
    jump = 1'b0;
    step();
    step();
    total++;
    if (runner_h !== 7'd1 || tick !== 1'b1) begin
      bad++;
      $display("FAIL jump_t1: h=%0d tick=%b want 1 1", runner_h, tick);
    end
    for (int t = 2; t <= 8; t++) begin
      step();
      if (t == 3) jump = 1'b1;
      step();
      jump = 1'b0;
      step();
      step();
      total++;
      if (runner_h !== 7'(exp_h[t-1])) begin
        bad++;
        $display("FAIL jump_seq: tick %0d h=%0d want %0d", t, runner_h, exp_h[t-1]);
      end
    end
    total++;
    if (collide !== 1'b1 || state !== 2'd2) begin
      bad++;
      $display("FAIL jump_land_hit: collide=%b state=%0d want 1 2", collide, state);
    end
  endtask

  task automatic test_collision();
    logic saw_early;
    saw_early = 1'b0;
    enter_run();
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i < 32 && collide !== 1'b0) saw_early = 1'b1;
      if (i == 4) begin
        total++;
        if (cols !== 16'h0003) begin
          bad++;
          $display("FAIL cols_t1: cols=%h want 0003", cols);
        end
      end
      if (i == 8) begin
        total++;
        if (cols !== 16'h000C) begin
          bad++;
          $display("FAIL cols_t2: cols=%h want 000c", cols);
        end
      end
      if (i == 16) begin
        total++;
        if (cols !== 16'h00C0) begin
          bad++;
          $display("FAIL cols_t4: cols=%h want 00c0", cols);
        end
      end
    end
    total++;
    if (saw_early) begin
      bad++;
      $display("FAIL early_collide: collide=1 before tick 8 want 0");
    end
    total++;
    if (collide !== 1'b1 || state !== 2'd2 || cols !== 16'hC000 || tick !== 1'b1) begin
      bad++;
      $display("FAIL hit: collide=%b state=%0d cols=%h tick=%b want 1 2 c000 1",
               collide, state, cols, tick);
    end
    step();
    total++;
    if (collide !== 1'b0 || state !== 2'd2) begin
      bad++;
      $display("FAIL hit_pulse: collide=%b state=%0d want 0 2", collide, state);
    end
    jump = 1'b1;
    saw_early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick !== 1'b0 || collide !== 1'b0) saw_early = 1'b1;
    end
    jump = 1'b0;
    total++;
    if (saw_early || cols !== 16'hC000 || runner_h !== 7'd0 || state !== 2'd2) begin
      bad++;
      $display("FAIL over_frozen: pulses=%b cols=%h h=%0d state=%0d want 0 c000 0 2",
               saw_early, cols, runner_h, state);
    end
    go = 1'b1;
    step();
    go = 1'b0;
    total++;
    if (state !== 2'd0 || cols !== 16'h0) begin
      bad++;
      $display("FAIL over_exit: state=%0d cols=%h want 0 0000", state, cols);
    end
  endtask

  task automatic test_stop_priority();
    enter_run();
    for (int i = 1; i <= 31; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (state !== 2'd0 || collide !== 1'b0 || cols !== 16'h0) begin
      bad++;
      $display("FAIL stop_prio: state=%0d collide=%b cols=%h want 0 0 0000", state, collide, cols);
    end
    step();
    total++;
    if (collide !== 1'b0 || tick !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL stop_after: collide=%b tick=%b state=%0d want 0 0 0", collide, tick, state);
    end
  endtask

  task automatic test_reset_mid_jump();
    enter_run();
    step();
    jump = 1'b1;
    step();
    jump = 1'b0;
    for (int i = 0; i < 14; i++) step();
    total++;
    if (runner_h !== 7'd4 || cols !== 16'h00C0) begin
      bad++;
      $display("FAIL pre_reset: h=%0d cols=%h want 4 00c0", runner_h, cols);
    end
    step();
    resetn = 1'b0;
    go = 1'b1;
    step();
    go = 1'b0;
    total++;
    if (state !== 2'd0 || tick !== 1'b0 || collide !== 1'b0 || cols !== 16'h0 ||
        runner_h !== 7'd0 || score !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: state=%0d tick=%b collide=%b cols=%h h=%0d score=%0d want all zero",
               state, tick, collide, cols, runner_h, score);
    end
    resetn = 1'b1;
  endtask

  task automatic test_score_off();
    int ticks;
    int cyc;
    ticks = 0;
    cyc = 0;
    enter_run();
    while (ticks < 1000 && cyc < 20000) begin
      go = (state != 2'd1);
      step();
      cyc++;
      if (tick === 1'b1) begin
        ticks++;
`ifndef RUNNER_SCORE_EN
        total++;
        if (score !== 16'h0) begin
          bad++;
          $display("FAIL score_off: tick %0d score=%0d want 0", ticks, score);
        end
`endif
      end
    end
    go = 1'b0;
    total++;
    if (ticks < 1000) begin
      bad++;
      $display("FAIL score_run_budget: ticks=%0d want 1000", ticks);
    end
  endtask

  initial begin
    resetn = 1'b0;
    go = 1'b0; stop = 1'b0; jump = 1'b0;
    @(negedge clk);
    test_reset();
    test_divider();
    test_jump();
    test_collision();
    test_stop_priority();
    test_reset_mid_jump();
    test_score_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/runner_world.md
RUNNER_WORLD -- requirements
Module: runner_world

Interface
REQ-001 SHALL have parameter COLS, default 80: number of obstacle columns; runner occupies column COLS-1.
REQ-002 SHALL have parameter OBS_W, default 2: obstacle height bits per column.
REQ-003 SHALL have parameter H_W, default 7: runner height width.
REQ-004 SHALL have parameter RATE, default 750000: clk cycles per game tick, at least 2.
REQ-005 SHALL have parameter HOLD, default 15: ticks of rise after an accepted jump.
REQ-006 SHALL have parameter SEED, default 16'hACE1: LFSR seed, nonzero.
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port resetn, input, 1, synchronous, active-low reset.
REQ-009 SHALL have ports go, stop and jump, each input, 1, level control inputs.
REQ-010 SHALL have port state, output, 2, FSM state: IDLE=0, RUN=1, OVER=2.
REQ-011 SHALL have port tick, output, 1, one-cycle game tick pulse.
REQ-012 SHALL have port cols, output, COLS*OBS_W, column heights; column k at bits [k*OBS_W +: OBS_W]; column 0 is newest.
REQ-013 SHALL have port runner_h, output, H_W, runner height above floor.
REQ-014 SHALL have port collide, output, 1, one-cycle pulse on a collision.
REQ-015 SHALL have port score, output, 16, count of cleared obstacles.

Function
REQ-016 FSM transitions SHALL be:
- IDLE->RUN when go is high.
- RUN->IDLE when stop is high.
- RUN->OVER on a collision tick.
- OVER->IDLE when go is high.
REQ-017 In RUN, stop SHALL take priority over a collision in the same cycle: next state IDLE, no collide pulse.
REQ-018 In IDLE, the block SHALL hold cols=0, runner_h=0, rise=0, jump_req=0, score=0, divider=RATE-1, LFSR=SEED and gap=0.
REQ-019 Divider SHALL count down only in RUN, pulse tick when it is 0 and reload RATE-1 in the same cycle; the first tick SHALL occur RATE cycles after entering RUN.
REQ-020 jump_req SHALL be set by jump high in any RUN cycle and cleared on every tick.
REQ-021 On tick, the 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance one step.
REQ-022 On tick, cols SHALL shift toward column COLS-1 by OBS_W, discarding the old column COLS-1; new column 0 SHALL be chosen as follows:
- 0 if gap>0; gap then decrements.
- Else lfsr[OBS_W-1:0] if lfsr[7:5]==0; if that value is nonzero, gap loads 2.
- Else 0.
REQ-023 On tick, runner update SHALL use the pre-tick runner_h, in this priority order:
- If jump_req or jump is high and runner_h==0: rise=HOLD, runner_h=1.
- Else if rise>0: rise decrements and runner_h increments, saturating at 2^H_W-1.
- Else if runner_h>0: runner_h decrements.
- Else: runner_h stays 0, with no underflow.
REQ-024 Collision SHALL be evaluated on the tick using the post-update values: zero-extended column COLS-1 > runner_h; it SHALL register collide=1 for exactly one cycle, concurrent with state becoming OVER.
REQ-025 In OVER, cols, runner_h, score, LFSR and the divider SHALL be frozen, and jump SHALL be ignored.
REQ-026 tick and collide SHALL never be high outside the cycle after a RUN tick.

Reset
REQ-027 resetn low at a clk edge SHALL force state=IDLE, tick=0, collide=0, cols=0, runner_h=0, score=0, LFSR=SEED, divider=RATE-1, rise=0, gap=0 and jump_req=0, including mid-RUN and mid-jump.
REQ-028 All registers SHALL be reset synchronously; reset SHALL take priority over go, stop and jump.

Configuration
REQ-029 With macro RUNNER_SCORE_EN defined, score SHALL increment, saturating at 16'hFFFF, on every non-collision tick where post-shift column COLS-1 is nonzero.
REQ-030 Without RUNNER_SCORE_EN, no score register SHALL be built and score SHALL be tied to 16'h0000; all other behaviour SHALL be unchanged.

Verification
REQ-031 Divider, with RATE=4: reset, go for 1 cycle -> state=1 next cycle; tick high on cycles 4, 8 and 12 after entry; nothing in IDLE.
REQ-032 Jump, with HOLD=3 and RATE=4: jump pulse 1 cycle mid-interval -> runner_h sequence over ticks 1,2,3,4,5,6,7,8 is 1,2,3,4,3,2,1,0; jump while runner_h>0 has no effect.
REQ-033 Collision, with COLS=8 and OBS_W=2: force column 7 to 3 with runner_h=0 on a tick -> collide high for 1 cycle, state=2, cols frozen; go -> state=0, cols=0.
REQ-034 Stop priority: stop asserted in the same cycle as a collision tick -> state=0, collide=0.
REQ-035 Reset mid-jump (runner_h=5, score=7) -> next cycle all outputs zero, state=0; with RUNNER_SCORE_EN undefined, score reads 0 throughout a 1000-tick run.
